// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding load or store, driving the byte-addressed data memory port.
// Build option LSU_MISALIGNED_SPLIT_EN splits misaligned HALF/WORD accesses into byte accesses.
package lsu_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_access_width_t;
endpackage

interface memory_port #(
  parameter int XLEN = 32
);
  import lsu_pkg::*;
  logic                 clk;
  logic [XLEN-1:0]      addr;
  memory_access_width_t width;
  logic [XLEN-1:0]      data_wr;
  logic [XLEN-1:0]      data_rd;
  logic                 read_en;
  logic                 write_en;

  modport requester (output clk, addr, width, data_wr, read_en, write_en, input data_rd);
  modport memory    (input clk, addr, width, data_wr, read_en, write_en, output data_rd);
endinterface

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  memory_access_width_t req_width,
  input  logic                 req_unsigned,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 rsp_valid,
  output logic [XLEN-1:0]      rsp_rdata,
  output logic                 rsp_error,
  output logic                 busy,
  memory_port.requester        mem_port
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e               state_q;
  logic                 write_q;
  logic                 unsigned_q;
  logic                 split_q;
  memory_access_width_t width_q;
  logic [XLEN-1:0]      addr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [XLEN-1:0]      raw_q;
  logic [XLEN-1:0]      raw_d;
  logic [1:0]           cnt_q;
  logic                 rsp_valid_q;
  logic                 rsp_error_q;
  logic [XLEN-1:0]      rsp_rdata_q;

  logic                 misaligned;
  logic                 last_byte;
  logic [XLEN-1:0]      mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  memory_access_width_t mem_width;
  logic                 mem_re;
  logic                 mem_we;

  function automatic logic [1:0] last_index(input memory_access_width_t w);
    case (w)
      BYTE:    return 2'd0;
      HALF:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] raw,
                                             input memory_access_width_t w,
                                             input logic uns);
    case (w)
      BYTE:    return uns ? {{(XLEN-8){1'b0}}, raw[7:0]} : {{(XLEN-8){raw[7]}}, raw[7:0]};
      HALF:    return uns ? {{(XLEN-16){1'b0}}, raw[15:0]} : {{(XLEN-16){raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign misaligned = ((req_width == HALF) && req_addr[0]) ||
                      ((req_width == WORD) && (req_addr[1:0] != 2'b00));
  assign last_byte  = !split_q || (cnt_q == last_index(width_q));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_width = BYTE;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    raw_d     = raw_q;
    if (state_q == ACCESS) begin
      mem_re = !write_q;
      mem_we = write_q;
      if (split_q) begin
        mem_addr  = addr_q + {{(XLEN-2){1'b0}}, cnt_q};
        mem_wdata = {{(XLEN-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
        raw_d[{cnt_q, 3'b000} +: 8] = mem_port.data_rd[7:0];
      end else begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_width = width_q;
        raw_d     = mem_port.data_rd;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      split_q     <= 1'b0;
      width_q     <= BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      raw_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_q    <= req_write;
            width_q    <= req_width;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            cnt_q      <= '0;
            raw_q      <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q    <= misaligned;
            state_q    <= ACCESS;
`else
            split_q    <= 1'b0;
            if (misaligned) begin
              // Rejected without touching memory; respond in the very next cycle.
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q <= ACCESS;
            end
`endif
          end
        end
        ACCESS: begin
          raw_q <= raw_d;
          if (last_byte) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= write_q ? '0 : extend(raw_d, width_q, unsigned_q);
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_error_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready         = (state_q == IDLE) && !rst;
  assign busy              = (state_q != IDLE);
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_error         = rsp_error_q;

  assign mem_port.clk      = clk;
  assign mem_port.addr     = mem_addr;
  assign mem_port.width    = mem_width;
  assign mem_port.data_wr  = mem_wdata;
  assign mem_port.read_en  = mem_re;
  assign mem_port.write_en = mem_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// compared against a byte-level reference memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  memory_access_width_t req_width;
  logic                 req_unsigned;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic [31:0]          rsp_rdata;
  logic                 rsp_error;
  logic                 busy;

  memory_port #(.XLEN(32)) mem_if ();

  load_store_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_width    (req_width),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .busy         (busy),
    .mem_port     (mem_if.requester)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int nb(input memory_access_width_t w);
    case (w)
      BYTE:    return 1;
      HALF:    return 2;
      default: return 4;
    endcase
  endfunction

  // Data memory: 4 KiB, addresses alias on their low 12 bits.
  bit   [7:0]  ram [4096];
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++)
      if (i < nb(mem_if.width)) rd_word[8*i +: 8] = ram[12'(mem_if.addr + 32'(i))];
  end
  assign mem_if.data_rd = rd_word;

  always @(posedge clk)
    if (mem_if.write_en)
      for (int i = 0; i < 4; i++)
        if (i < nb(mem_if.width)) ram[12'(mem_if.addr + 32'(i))] <= mem_if.data_wr[8*i +: 8];

  logic [31:0] acc_q[$];
  always @(posedge clk)
    if (mem_if.read_en || mem_if.write_en) acc_q.push_back(mem_if.addr);

  // Reference model state
  bit   [7:0]  ref_mem [4096];
  logic [31:0] exp_acc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: applies the request to ref_mem and predicts the response.
  task automatic model(input bit wr, input memory_access_width_t w, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] e_rdata, output logic e_err, output int e_lat);
    int          k;
    bit          mis;
    logic [31:0] val;
    logic [31:0] ba;
    k       = nb(w);
    mis     = (a % k) != 0;
    e_rdata = '0;
    e_err   = 1'b0;
    val     = '0;
    exp_acc.delete();
    if (mis && !SPLIT) begin
      e_err = 1'b1;
      e_lat = 1;
      return;
    end
    for (int i = 0; i < k; i++) begin
      ba = a + 32'(i);
      if (mis) exp_acc.push_back(ba);
      if (wr) ref_mem[ba[11:0]] = wd[8*i +: 8];
      else    val = val | (32'(ref_mem[ba[11:0]]) << (8*i));
    end
    if (!mis) exp_acc.push_back(a);
    if (!wr) begin
      if (k < 4 && !uns && val[8*k-1]) val = val - (32'd1 << (8*k));
      e_rdata = val;
    end
    e_lat = mis ? k + 1 : 2;
  endtask

  task automatic do_req(input bit wr, input memory_access_width_t w, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat;
    int          n;
    int          base;
    bit          got;
    model(wr, w, uns, a, wd, e_rdata, e_err, e_lat);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_width = w; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("ready_wait", 32'(n < 20), 32'd1);
    base = acc_q.size();
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    for (n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_c1", 32'(busy), 32'd1);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(e_lat));
    check("rsp_error", 32'(rsp_error), 32'(e_err));
    check("rsp_rdata", rsp_rdata, e_rdata);
    check("n_access", 32'(acc_q.size() - base), 32'(exp_acc.size()));
    for (int i = 0; i < exp_acc.size(); i++)
      if (base + i < acc_q.size()) check("acc_addr", acc_q[base+i], exp_acc[i]);
    for (int j = -1; j <= 4; j++)
      check("mem_byte", 32'(ram[12'(a + 32'(j))]), 32'(ref_mem[12'(a + 32'(j))]));
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("ready_after_resp", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d_rdata;
    logic        d_err;
    int          d_lat;
    logic [31:0] rst_addr;
    int          rst_cyc;
    int          n_commit;
    bit          seen;
    int          last_acc;
    int          n_acc;
    int          rsp_cnt;
    int          idx;
    bit          acc;
    logic [31:0] b2b_data [3];

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_width = BYTE;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'({mem_if.read_en, mem_if.write_en}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 32'd1);

    // Word round trip and sub-word loads
    do_req(1'b1, WORD, 1'b0, 32'h100, 32'hDEADBEEF);
    do_req(1'b0, WORD, 1'b0, 32'h100, 32'h0);
    check("word_rt", rsp_rdata, 32'h0);  // response has cleared after RESP
    do_req(1'b0, BYTE, 1'b0, 32'h101, 32'h0);
    do_req(1'b0, BYTE, 1'b1, 32'h101, 32'h0);
    do_req(1'b0, HALF, 1'b0, 32'h102, 32'h0);
    do_req(1'b0, HALF, 1'b1, 32'h102, 32'h0);

    // Misaligned half store into a pre-filled word
    do_req(1'b1, WORD, 1'b0, 32'h200, 32'h44332211);
    do_req(1'b1, HALF, 1'b0, 32'h201, 32'h00001234);
    do_req(1'b0, WORD, 1'b0, 32'h200, 32'h0);

    // Address wrap across 0xFFFF_FFFF
    do_req(1'b1, HALF, 1'b0, 32'hFFFF_FFFE, 32'h00005566);
    do_req(1'b1, HALF, 1'b0, 32'h0000_0000, 32'h00007788);
    do_req(1'b0, WORD, 1'b0, 32'hFFFF_FFFE, 32'h0);
    do_req(1'b0, HALF, 1'b0, 32'hFFFF_FFFF, 32'h0);

    // Reset in the middle of a store
    do_req(1'b1, WORD, 1'b0, 32'h300, 32'h44332211);
    do_req(1'b1, WORD, 1'b0, 32'h304, 32'h88776655);
    rst_addr = SPLIT ? 32'h301 : 32'h300;
    rst_cyc  = SPLIT ? 2 : 1;
    n_commit = SPLIT ? 2 : 4;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = WORD; req_unsigned = 1'b0;
    req_addr = rst_addr; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= rst_cyc; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("midop_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midop_rst_ready", 32'(req_ready), 32'd0);
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_en", 32'({mem_if.read_en, mem_if.write_en}), 32'd0);
    if (rsp_valid) seen = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("midop_ready_after", 32'(req_ready), 32'd1);
    repeat (3) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("midop_no_rsp", 32'(seen), 32'd0);
    for (int i = 0; i < n_commit; i++) ref_mem[12'(rst_addr + 32'(i))] = 8'(32'hAABBCCDD >> (8*i));
    for (int j = 0; j < 8; j++)
      check("midop_mem", 32'(ram[12'(32'h300 + 32'(j))]), 32'(ref_mem[12'(32'h300 + 32'(j))]));

    // Back-to-back stores with req_valid held high
    for (int i = 0; i < 3; i++) b2b_data[i] = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = WORD; req_unsigned = 1'b0;
    req_addr = 32'h400; req_wdata = b2b_data[0];
    idx = 0; last_acc = -1; n_acc = 0; rsp_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (rsp_valid) rsp_cnt++;
      acc = req_ready && req_valid;
      if (acc) begin
        n_acc++;
        if (last_acc >= 0) check("b2b_spacing", 32'(c - last_acc), 32'd3);
        last_acc = c;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        model(1'b1, WORD, 1'b0, req_addr, req_wdata, d_rdata, d_err, d_lat);
        idx++;
        if (idx == 3) req_valid = 1'b0;
        else begin
          req_addr  = 32'h400 + 32'(4*idx);
          req_wdata = b2b_data[idx];
        end
      end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(n_acc), 32'd3);
    check("b2b_rsp_count", 32'(rsp_cnt), 32'd3);
    for (int j = 0; j < 12; j++)
      check("b2b_mem", 32'(ram[12'(32'h400 + 32'(j))]), 32'(ref_mem[12'(32'h400 + 32'(j))]));

    // Random traffic in a 256-byte window
    for (int t = 0; t < 80; t++)
      do_req(1'($urandom), memory_access_width_t'($urandom_range(0, 2)), 1'($urandom),
             32'h500 + 32'($urandom_range(0, 255)), $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
